// File: rtl/scs8hd_bist_pkg.sv
// Shared types and constants for the scs8hd_o2bb2ai BIST sequencer.
// MISR helpers are only used when SCS8HD_BIST_MISR_EN is defined.
package scs8hd_bist_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StDone
  } bist_state_e;

  localparam int unsigned NumVecs  = 16;
  localparam int unsigned VecW     = 4;
  localparam int unsigned CntW     = 8;
  localparam int unsigned FailW    = 5;
  localparam int unsigned MisrW    = 8;

  // Bit v is the o2bb2ai output for {A1N,A2N,B1,B2} = v.
  localparam logic [NumVecs-1:0] GoldenMask = 16'hF111;

  // Feedback taps for x^8+x^6+x^5+x^4+1, as bit indices 7,5,4,3 of the shift register.
  localparam logic [MisrW-1:0] MisrTaps = 8'hB8;

  function automatic logic golden_y(input logic [VecW-1:0] vec);
    return GoldenMask[vec];
  endfunction

  function automatic logic [MisrW-1:0] misr_next(input logic [MisrW-1:0] cur, input logic y);
    logic fb;
    fb = ^(cur & MisrTaps);
    return {cur[MisrW-2:0], fb ^ y};
  endfunction

endpackage

// File: rtl/scs8hd_o2bb2ai_bist_if.sv
// Bundle of the cell-under-test drives, start control and result outputs of the BIST.
interface scs8hd_o2bb2ai_bist_if #(
  parameter int unsigned SIG_W = 8
);
  logic             start;
  logic             Y;
  logic             A1N;
  logic             A2N;
  logic             B1;
  logic             B2;
  logic             busy;
  logic             done;
  logic             pass;
  logic [4:0]       fail_cnt;
  logic [3:0]       first_fail_vec;
  logic             first_fail_valid;
  logic [SIG_W-1:0] signature;

  // master: the BIST sequencer itself.
  modport master (
    input  start, Y,
    output A1N, A2N, B1, B2, busy, done, pass, fail_cnt, first_fail_vec, first_fail_valid,
    output signature
  );

  // slave: the wrapper / cell side that starts runs and returns Y.
  modport slave (
    output start, Y,
    input  A1N, A2N, B1, B2, busy, done, pass, fail_cnt, first_fail_vec, first_fail_valid,
    input  signature
  );
endinterface

// File: rtl/scs8hd_bist_misr.sv
// 8-bit Fibonacci MISR compacting the sampled Y stream of one BIST run.
// Only instantiated when SCS8HD_BIST_MISR_EN is defined.
module scs8hd_bist_misr
  import scs8hd_bist_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic             y_i,
  output logic [MisrW-1:0] sig_o
);

  logic [MisrW-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clear_i) begin
      sig_d = '0;
    end else if (en_i) begin
      sig_d = misr_next(sig_q, y_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/scs8hd_o2bb2ai_bist.sv
// BIST sequencer: walks the o2bb2ai cell through all 16 input vectors and checks Y.
// Optional MISR signature is built when SCS8HD_BIST_MISR_EN is defined.
module scs8hd_o2bb2ai_bist
  import scs8hd_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned SIG_W         = 8
) (
  input logic                  CLK,
  input logic                  RESET,
  scs8hd_o2bb2ai_bist_if.master bus
);

  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);
  localparam logic [VecW-1:0] LastVec    = VecW'(NumVecs - 1);

  bist_state_e      state_q, state_d;
  logic [VecW-1:0]  vec_q, vec_d;
  logic [CntW-1:0]  settle_cnt_q, settle_cnt_d;
  logic [FailW-1:0] fail_cnt_q, fail_cnt_d;
  logic [VecW-1:0]  first_fail_vec_q, first_fail_vec_d;
  logic             first_fail_valid_q, first_fail_valid_d;
  logic             mismatch;

  assign mismatch = bus.Y != golden_y(vec_q);

  always_comb begin
    state_d            = state_q;
    vec_d              = vec_q;
    settle_cnt_d       = settle_cnt_q;
    fail_cnt_d         = fail_cnt_q;
    first_fail_vec_d   = first_fail_vec_q;
    first_fail_valid_d = first_fail_valid_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d            = StSettle;
          vec_d              = '0;
          settle_cnt_d       = '0;
          fail_cnt_d         = '0;
          first_fail_vec_d   = '0;
          first_fail_valid_d = 1'b0;
        end
      end
      StSettle: begin
        if (settle_cnt_q == SettleLast) begin
          state_d = StSample;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      StSample: begin
        if (mismatch) begin
          fail_cnt_d = fail_cnt_q + 1'b1;
          if (!first_fail_valid_q) begin
            first_fail_vec_d   = vec_q;
            first_fail_valid_d = 1'b1;
          end
        end
        if (vec_q == LastVec) begin
          state_d = StDone;
        end else begin
          state_d      = StSettle;
          vec_d        = vec_q + 1'b1;
          settle_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q            <= StIdle;
      vec_q              <= '0;
      settle_cnt_q       <= '0;
      fail_cnt_q         <= '0;
      first_fail_vec_q   <= '0;
      first_fail_valid_q <= 1'b0;
    end else begin
      state_q            <= state_d;
      vec_q              <= vec_d;
      settle_cnt_q       <= settle_cnt_d;
      fail_cnt_q         <= fail_cnt_d;
      first_fail_vec_q   <= first_fail_vec_d;
      first_fail_valid_q <= first_fail_valid_d;
    end
  end

  // The vector register doubles as the registered drive to the cell.
  assign bus.A1N              = vec_q[3];
  assign bus.A2N              = vec_q[2];
  assign bus.B1               = vec_q[1];
  assign bus.B2               = vec_q[0];
  assign bus.busy             = (state_q == StSettle) || (state_q == StSample);
  assign bus.done             = (state_q == StDone);
  assign bus.pass             = (state_q == StDone) && (fail_cnt_q == '0);
  assign bus.fail_cnt         = fail_cnt_q;
  assign bus.first_fail_vec   = first_fail_vec_q;
  assign bus.first_fail_valid = first_fail_valid_q;

`ifdef SCS8HD_BIST_MISR_EN
  logic             misr_clear;
  logic             misr_en;
  logic [MisrW-1:0] misr_sig;

  assign misr_clear = ((state_q == StIdle) || (state_q == StDone)) && bus.start;
  assign misr_en    = (state_q == StSample);

  scs8hd_bist_misr u_misr (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .clear_i (misr_clear),
    .en_i    (misr_en),
    .y_i     (bus.Y),
    .sig_o   (misr_sig)
  );

  assign bus.signature = SIG_W'(misr_sig);
`else
  assign bus.signature = '0;
`endif

endmodule

// File: tb/tb_scs8hd_o2bb2ai_bist.sv
// Self-checking bench for scs8hd_o2bb2ai_bist with a behavioural cell and result model.
module tb_scs8hd_o2bb2ai_bist;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scs8hd_o2bb2ai_bist_if #(.SIG_W(8)) bus_if ();

  scs8hd_o2bb2ai_bist #(
    .SETTLE_CYCLES (2),
    .SIG_W         (8)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus_if)
  );

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int          mode     = 0;
  logic [15:0] rand_y   = '0;

  function automatic logic golden(input logic [3:0] v);
    return (v[3] & v[2]) | ~(v[1] | v[0]);
  endfunction

  // mode 0: good cell, 1: stuck-at-0, 2: stuck-at-1, 3: random per-vector response
  function automatic logic cell_y(input int m, input logic [3:0] v, input logic [15:0] r);
    case (m)
      0:       return golden(v);
      1:       return 1'b0;
      2:       return 1'b1;
      default: return r[v];
    endcase
  endfunction

  always_comb bus_if.Y = cell_y(mode, {bus_if.A1N, bus_if.A2N, bus_if.B1, bus_if.B2}, rand_y);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".drv"}, 32'({bus_if.A1N, bus_if.A2N, bus_if.B1, bus_if.B2}), 0);
    check({tag, ".busy"}, 32'(bus_if.busy), 0);
    check({tag, ".done"}, 32'(bus_if.done), 0);
    check({tag, ".pass"}, 32'(bus_if.pass), 0);
    check({tag, ".fail_cnt"}, 32'(bus_if.fail_cnt), 0);
    check({tag, ".ffv"}, 32'(bus_if.first_fail_vec), 0);
    check({tag, ".ffvalid"}, 32'(bus_if.first_fail_valid), 0);
    check({tag, ".sig"}, 32'(bus_if.signature), 0);
  endtask

  // One full run from IDLE/DONE; hold keeps start high until just before done.
  task automatic run(input int m, input bit hold, input string tag);
    int          exp_fail  = 0;
    int          exp_first = -1;
    logic [7:0]  exp_sig   = '0;
    logic        y;
    for (int v = 0; v < 16; v++) begin
      y = cell_y(m, 4'(v), rand_y);
      if (y != golden(4'(v))) begin
        exp_fail++;
        if (exp_first < 0) exp_first = v;
      end
      exp_sig = {exp_sig[6:0], exp_sig[7] ^ exp_sig[5] ^ exp_sig[4] ^ exp_sig[3] ^ y};
    end
    mode = m;
    @(negedge clk);
    bus_if.start = 1'b1;
    for (int k = 0; k <= 48; k++) begin
      @(posedge clk);
      #1;
      if ((!hold && k == 0) || (hold && k == 47)) bus_if.start = 1'b0;
      if (k == 0) begin
        check($sformatf("%s.clr_fail", tag), 32'(bus_if.fail_cnt), 0);
        check($sformatf("%s.clr_ffvalid", tag), 32'(bus_if.first_fail_valid), 0);
        check($sformatf("%s.clr_ffv", tag), 32'(bus_if.first_fail_vec), 0);
        check($sformatf("%s.clr_sig", tag), 32'(bus_if.signature), 0);
      end
      check($sformatf("%s.drv%0d", tag, k),
            32'({bus_if.A1N, bus_if.A2N, bus_if.B1, bus_if.B2}), (k >= 48) ? 15 : k / 3);
      check($sformatf("%s.busy%0d", tag, k), 32'(bus_if.busy), (k < 48) ? 1 : 0);
      check($sformatf("%s.done%0d", tag, k), 32'(bus_if.done), (k == 48) ? 1 : 0);
`ifndef SCS8HD_BIST_MISR_EN
      check($sformatf("%s.sig0_%0d", tag, k), 32'(bus_if.signature), 0);
`endif
    end
    check({tag, ".pass"}, 32'(bus_if.pass), (exp_fail == 0) ? 1 : 0);
    check({tag, ".fail_cnt"}, 32'(bus_if.fail_cnt), 32'(exp_fail));
    check({tag, ".ffvalid"}, 32'(bus_if.first_fail_valid), (exp_first >= 0) ? 1 : 0);
    check({tag, ".ffv"}, 32'(bus_if.first_fail_vec), (exp_first >= 0) ? 32'(exp_first) : 0);
`ifdef SCS8HD_BIST_MISR_EN
    check({tag, ".sig"}, 32'(bus_if.signature), 32'(exp_sig));
`else
    check({tag, ".sig"}, 32'(bus_if.signature), 0);
`endif
    // Results must hold in DONE while start stays low.
    repeat (3) @(posedge clk);
    #1;
    check({tag, ".hold_done"}, 32'(bus_if.done), 1);
    check({tag, ".hold_fail"}, 32'(bus_if.fail_cnt), 32'(exp_fail));
    check({tag, ".hold_drv"}, 32'({bus_if.A1N, bus_if.A2N, bus_if.B1, bus_if.B2}), 15);
  endtask

  initial begin
    rst          = 1'b1;
    bus_if.start = 1'b0;
    #2;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("idle");

    run(0, 1'b0, "good");
    run(1, 1'b0, "sa0");
    run(2, 1'b0, "sa1");
    rand_y = 16'($urandom);
    run(3, 1'b0, "rand_a");
    rand_y = 16'($urandom);
    run(3, 1'b0, "rand_b");

    // Reset mid-run while vector 7 is settling.
    mode = 1;
    @(negedge clk);
    bus_if.start = 1'b1;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    repeat (22) @(posedge clk);
    #1;
    check("mid.drv", 32'({bus_if.A1N, bus_if.A2N, bus_if.B1, bus_if.B2}), 7);
    check("mid.busy", 32'(bus_if.busy), 1);
    check("mid.fail_cnt", 32'(bus_if.fail_cnt), 2);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("post_rst");
    run(0, 1'b0, "after_rst");

    // Start held through a failing run, then a fresh start from DONE must clear and rerun.
    run(1, 1'b1, "held");
    run(0, 1'b0, "rerun");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/scs8hd_o2bb2ai_bist.md
# scs8hd_o2bb2ai_bist

Built-in self-test sequencer for the scs8hd_o2bb2ai cell family. It drives the cell's four inputs through all 16 combinations, waits a programmable settle time, and samples the cell output Y. It compares each sample against the golden function, Y = (A1N & A2N) | ~(B1 | B2), and reports the result. The block sits beside a cell-under-test instance in characterization and test-chip wrappers, on the cell's clock domain.

## Interface
- SETTLE_CYCLES, default 2: cycles held per vector before sampling; legal range 1..255.
- SIG_W, default 8: MISR signature width; fixed at 8 in this revision.

- CLK  input  1  sole clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- start  input  1  in IDLE or DONE, a high level at an edge starts a run.
- Y  input  1  output of the cell under test.
- A1N, A2N, B1, B2  output  1 each  registered drives to the cell under test; reset 0.
- busy  output  1  high in SETTLE/SAMPLE; reset 0.
- done  output  1  high in DONE; reset 0.
- pass  output  1  valid when done=1; equals (fail_cnt==0); reset 0.
- fail_cnt  output  5  mismatch count, 0..16, saturation impossible; reset 0.
- first_fail_vec  output  4  index of first mismatching vector; reset 0.
- first_fail_valid  output  1  set on first mismatch of a run; reset 0.
- signature  output  SIG_W  MISR value; reset 0; constant 0 when the MISR is compiled out.

## Operation
- Vector mapping: {A1N,A2N,B1,B2} = vec[3:0]; vec counts 0..15 ascending.
- Expected ones at vec 0,4,8,12,13,14,15. All other vectors expect zero.
- States:
  - IDLE: waits for start.
  - SETTLE: settle_cnt counts 0..SETTLE_CYCLES-1, then goes to SAMPLE.
  - SAMPLE: compares Y against the expected value for vec.
    - vec==15: go to DONE.
    - otherwise: vec++, settle_cnt=0, back to SETTLE.
  - DONE: waits for start.
- Start accept, from IDLE or DONE:
  - vec=0 and settle_cnt=0; go to SETTLE.
  - Clear fail_cnt, first_fail_*, and signature.
- Mismatch in SAMPLE:
  - fail_cnt++.
  - If first_fail_valid==0, capture vec into first_fail_vec and set first_fail_valid.
- start while busy is ignored.
- In DONE the drive outputs hold vector 15 and results hold until the next accept.
- RESET at any time, including mid-run: every register returns to its reset value and the block enters IDLE. No partial result is retained.

## Timing
- Drive outputs change on the edge that enters SETTLE. Y is sampled on the SAMPLE edge, SETTLE_CYCLES+1 edges after that drive change.
- Each vector takes SETTLE_CYCLES+1 cycles. done rises 16*(SETTLE_CYCLES+1) edges after the accept edge (48 edges for default S=2).
- busy and done are never high together. busy falls on the same edge that done rises.
- Y is treated as synchronous to CLK. Any path delay of the cell under test must fit within the settle window.

## Configuration
- SCS8HD_BIST_MISR_EN defined:
  - An 8-bit MISR (x^8+x^6+x^5+x^4+1, Fibonacci) updates once per SAMPLE edge.
  - Y is XORed into bit 0.
  - signature holds the final value in DONE.
- Not defined: no MISR logic; signature is tied to 0. All other behaviour is identical.

## Structure
- Package scs8hd_bist_pkg holds:
  - state enum {IDLE, SETTLE, SAMPLE, DONE};
  - the o2bb2ai golden-function constant (16-bit truth mask 16'hF111);
  - the MISR polynomial constant.
- One sub-module, scs8hd_bist_misr, instantiated only under SCS8HD_BIST_MISR_EN.

## Test plan
- Correct cell model, S=2, start pulse:
  - done after 48 cycles;
  - pass=1, fail_cnt=0, first_fail_valid=0;
  - drives step 0x0..0xF every 3 cycles.
- Y stuck-at-0: fail_cnt=7, first_fail_vec=0, pass=0.
- Y stuck-at-1: fail_cnt=9, first_fail_vec=1, pass=0.
- RESET asserted at vec=7 mid-SETTLE:
  - all outputs go to 0 immediately (asynchronous), state IDLE;
  - a new start then completes with correct results.
- start held high through a whole run and pulsed again in DONE:
  - mid-run start has no effect;
  - the DONE start clears results and reruns, with done low for 48 cycles.
- Macro defined, correct cell: signature matches the bench MISR model fed the expected sequence. Macro undefined: signature=0 throughout.
